// File: rtl/osd_cmd_tx.sv
// OSD io bus initiator: frames one header word plus payload words
// fetched from a local word memory, with configurable bus timing.
module osd_cmd_tx #(
    parameter int SETUP     = 2,
    parameter int STROBE_HI = 1,
    parameter int STROBE_LO = 2,
    parameter int HOLD      = 1,
    parameter int GAP       = 2,
    parameter int AW        = 13
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_word,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          abort,
    output logic [AW-1:0] rd_addr,
    input  logic [15:0]   rd_data,
    output logic          io_osd,
    output logic          io_strobe,
    output logic [15:0]   io_din,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STRB_H,
        S_STRB_L,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] SETUP_L = 8'(SETUP - 1);
    localparam logic [7:0] HI_L    = 8'(STROBE_HI - 1);
    localparam logic [7:0] LO_L    = 8'(STROBE_LO - 1);
    localparam logic [7:0] HOLD_L  = 8'(HOLD - 1);
    // GAP state covers GAP-1 cycles; the IDLE accept cycle is the last low one
    localparam logic [7:0] GAP_L   = 8'(GAP - 2);

    state_t        state, state_d;
    logic [7:0]    cnt, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          fetch_q, fetch_d;
    logic          loaded_q, loaded_d;
    logic          abort_q, abort_d;
    logic          abort_seen;
    logic [AW-1:0] rd_addr_d;
    logic [15:0]   io_din_d;

    // State, counters and all bus outputs are registered here
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            fetch_q   <= 1'b0;
            loaded_q  <= 1'b0;
            abort_q   <= 1'b0;
            rd_addr   <= '0;
            io_din    <= '0;
            io_osd    <= 1'b0;
            io_strobe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            fetch_q   <= fetch_d;
            loaded_q  <= loaded_d;
            abort_q   <= abort_d;
            rd_addr   <= rd_addr_d;
            io_din    <= io_din_d;
            io_osd    <= state_d inside {S_SETUP, S_STRB_H, S_STRB_L, S_HOLD};
            io_strobe <= (state_d == S_STRB_H);
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_HOLD) && (cnt_d == HOLD_L);
            cmd_ready <= (state_d == S_IDLE);
        end
    end

    // Next-state, word fetch and abort tracking
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 8'd1;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        fetch_d    = fetch_q;
        loaded_d   = loaded_q;
        abort_d    = abort_q;
        rd_addr_d  = rd_addr;
        io_din_d   = io_din;
        abort_seen = abort_q | abort;
        unique case (state)
            S_IDLE: begin
                cnt_d    = '0;
                abort_d  = 1'b0;
                fetch_d  = 1'b0;
                loaded_d = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    state_d  = S_SETUP;
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    idx_d    = '0;
                    io_din_d = {8'h00, cmd_word};
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_L) begin
                    state_d = S_STRB_H;
                    cnt_d   = '0;
                end
            end
            S_STRB_H: begin
                abort_d = abort_seen;
                if (cnt == HI_L) begin
                    state_d = S_STRB_L;
                    cnt_d   = '0;
                    // address goes out in low cycle 0 (sum wraps at 2^AW)
                    if ((idx_q < len_q) && !abort_seen) begin
                        rd_addr_d = addr_q + idx_q;
                        fetch_d   = 1'b1;
                    end
                end
            end
            S_STRB_L: begin
                abort_d = abort_seen;
                // memory answers one cycle after the address
                if ((cnt == 8'd1) && fetch_q && !abort_seen) begin
                    io_din_d = rd_data;
                    idx_d    = idx_q + AW'(1);
                    loaded_d = 1'b1;
                    fetch_d  = 1'b0;
                end
                if (cnt == LO_L) begin
                    cnt_d    = '0;
                    state_d  = (loaded_d && !abort_seen) ? S_STRB_H : S_HOLD;
                    loaded_d = 1'b0;
                    fetch_d  = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_L) begin
                    cnt_d   = '0;
                    state_d = (GAP > 1) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt == GAP_L) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_osd_cmd_tx.sv
// Directed bench for osd_cmd_tx: header-only, palette, wrap,
// back-to-back, abort and mid-frame reset.
module tb_osd_cmd_tx;

    localparam int AW = 13;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_word;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          abort;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data = '0;
    logic          io_osd;
    logic          io_strobe;
    logic [15:0]   io_din;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0]   q_din[$];
    logic [AW-1:0] q_addr[$];
    logic          ps      = 1'b0;
    int            hi_run  = 0;
    int            lo_run  = 0;
    int            last_hi = 0;
    int            last_lo = 0;
    int            n_done  = 0;
    int            n_acc   = 0;

    osd_cmd_tx dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_word  (cmd_word),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .io_osd    (io_osd),
        .io_strobe (io_strobe),
        .io_din    (io_din),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        return 16'hA000 + 16'(a) - 16'h0100;
    endfunction

    // Source memory: one cycle read latency
    always @(posedge clk_sys) rd_data <= mem_word(rd_addr);

    always @(posedge clk_sys) if (cmd_valid && cmd_ready) n_acc <= n_acc + 1;

    // Bus monitor on the falling edge
    always @(negedge clk_sys) begin
        ps <= io_strobe;
        if (io_strobe && !ps) begin
            q_din.push_back(io_din);
            q_addr.push_back(rd_addr);
        end
        if (io_osd) hi_run <= hi_run + 1;
        else if (hi_run != 0) begin
            last_hi <= hi_run;
            hi_run  <= 0;
        end
        if (!io_osd) lo_run <= lo_run + 1;
        else if (lo_run != 0) begin
            last_lo <= lo_run;
            lo_run  <= 0;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [AW-1:0] a,
                        input logic [AW-1:0] l);
        int t;
        @(negedge clk_sys);
        cmd_word  = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
        chk("ready_wait", {31'b0, t < 100}, 32'd1);
        @(negedge clk_sys);
        cmd_valid = 1'b0;
        cmd_word  = 8'hFF;
        cmd_addr  = '1;
        cmd_len   = 13'd3;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 5000) begin
            @(negedge clk_sys);
            t++;
        end
        chk(tag, {31'b0, t < 5000}, 32'd1);
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic clear_q();
        q_din.delete();
        q_addr.delete();
    endtask

    task automatic check_frame(input string tag, input logic [15:0] hdr,
                               input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        chk({tag, "_nstrb"}, q_din.size(), n + 1);
        if (q_din.size() > 0) chk({tag, "_hdr"}, q_din[0], hdr);
        for (int k = 1; k <= n && k < q_din.size(); k++) begin
            a = base + AW'(k - 1);
            chk({tag, "_addr"}, q_addr[k], a);
            chk({tag, "_data"}, q_din[k], mem_word(a));
        end
    endtask

    task automatic wait_strobes(input int n);
        int s;
        int t;
        s = 0;
        t = 0;
        while (s < n && t < 2000) begin
            @(negedge clk_sys);
            t++;
            if (io_strobe) s++;
        end
        chk("strobe_wait", {31'b0, t < 2000}, 32'd1);
    endtask

    initial begin
        int d0;
        int a0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_word  = '0;
        cmd_addr  = '0;
        cmd_len   = '0;
        repeat (2) @(negedge clk_sys);
        chk("rst_osd", io_osd, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_din", io_din, 16'h0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("rel_ready", cmd_ready, 1'b1);

        // abort while idle has no effect
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        chk("idle_abort_busy", busy, 1'b0);

        // Header-only disable command
        clear_q();
        d0 = n_done;
        send(8'h40, '0, '0);
        chk("dis_busy", busy, 1'b1);
        wait_idle("dis_idle");
        chk("dis_nstrb", q_din.size(), 1);
        if (q_din.size() > 0) chk("dis_hdr", q_din[0], 16'h0040);
        chk("dis_hi", last_hi, 6);
        chk("dis_done", n_done - d0, 1);
        chk("dis_keep", io_din, 16'h0040);

        // Palette: 8 words from 0x100
        clear_q();
        d0 = n_done;
        send(8'h80, 13'h0100, 13'd8);
        wait_idle("pal_idle");
        check_frame("pal", 16'h0080, 13'h0100, 8);
        chk("pal_hi", last_hi, 30);
        chk("pal_done", n_done - d0, 1);
        chk("pal_keep", io_din, 16'hA007);

        // Address wrap across 0x1FFF
        clear_q();
        send(8'h28, 13'h1FF0, 13'd32);
        wait_idle("wrap_idle");
        check_frame("wrap", 16'h0028, 13'h1FF0, 32);
        if (q_addr.size() > 17) chk("wrap_zero", q_addr[17], 13'h0000);
        chk("wrap_hi", last_hi, 102);

        // Back-to-back with cmd_valid held
        clear_q();
        d0 = n_done;
        a0 = n_acc;
        @(negedge clk_sys);
        cmd_word  = 8'h41;
        cmd_addr  = 13'h0200;
        cmd_len   = 13'd5;
        cmd_valid = 1'b1;
        for (int t = 0; t < 500 && n_acc < a0 + 2; t++) @(negedge clk_sys);
        cmd_valid = 1'b0;
        chk("b2b_acc", n_acc - a0, 2);
        wait_idle("b2b_idle");
        chk("b2b_nstrb", q_din.size(), 12);
        chk("b2b_gap", last_lo, 2);
        chk("b2b_hi", last_hi, 21);
        chk("b2b_done", n_done - d0, 2);
        if (q_din.size() > 11) begin
            chk("b2b_hdr2", q_din[6], 16'h0041);
            chk("b2b_last", q_din[11], 16'hA104);
        end

        // Abort during strobe-high of the fifth payload word
        clear_q();
        d0 = n_done;
        send(8'h20, 13'h0300, 13'd100);
        wait_strobes(6);
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        wait_idle("abt_idle");
        chk("abt_nstrb", q_din.size(), 6);
        chk("abt_done", n_done - d0, 1);
        chk("abt_hi", last_hi, 21);
        chk("abt_keep", io_din, 16'hA204);

        // Reset during the third payload word
        clear_q();
        send(8'h20, 13'h0300, 13'd100);
        wait_strobes(4);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("mrst_osd", io_osd, 1'b0);
        chk("mrst_strb", io_strobe, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_ready", cmd_ready, 1'b0);
        chk("mrst_din", io_din, 16'h0);
        chk("mrst_addr", rd_addr, 13'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("mrst_rel_ready", cmd_ready, 1'b1);
        repeat (10) @(negedge clk_sys);
        chk("mrst_nstrb", q_din.size(), 4);
        chk("mrst_osd_after", io_osd, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
